dual_rail_capture: RTL and testbench

DUAL_RAIL_CAPTURE -- requirements
Module: dual_rail_capture

---
 rtl/dual_rail_pkg.sv | 37 +++
 rtl/dual_rail_decode.sv | 39 +++
 rtl/dual_rail_capture.sv | 126 ++++++++++++
 tb/tb_dual_rail_capture.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_rail_pkg.sv
// ---------------------------------------------------------------------------
// dual_rail_pkg
// Shared types and constants for the dual-rail capture block.
//   capture_entry_t : one buffer entry, {ok, data_bit}
//   state_t         : capture controller states
//   CODE_*          : the four possible dual-rail code words
// ---------------------------------------------------------------------------
package dual_rail_pkg;

  // "bit" is a reserved word in SystemVerilog, so the value field is named
  // data_bit; the packed layout is still {ok, bit}.
  typedef struct packed {
    logic ok;
    logic data_bit;
  } capture_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NULL    = 2'b00;
  localparam logic [1:0] CODE_ZERO    = 2'b01;
  localparam logic [1:0] CODE_ONE     = 2'b10;
  localparam logic [1:0] CODE_ILLEGAL = 2'b11;

  // Builds the stored form of a decoded code. Illegal codes store {0,0}, so
  // the value bit is forced low whenever ok is low.
  function automatic capture_entry_t make_entry(input logic ok, input logic b);
    capture_entry_t e;
    e.ok       = ok;
    e.data_bit = ok & b;
    return e;
  endfunction

endpackage

// File: rtl/dual_rail_decode.sv
// ---------------------------------------------------------------------------
// dual_rail_decode
// Purely combinational classifier for one dual-rail code word {a, ~a}.
// Ports:
//   code     in  2  code word from the writer side
//   code_bit out 1  decoded value (0 unless the code is a valid data word)
//   ok       out 1  code is a valid data word (01 or 10)
//   is_null  out 1  code is the spacer 00
//   illegal  out 1  code is the forbidden 11
// ---------------------------------------------------------------------------
module dual_rail_decode
  import dual_rail_pkg::*;
(
  input  logic [1:0] code,
  output logic       code_bit,
  output logic       ok,
  output logic       is_null,
  output logic       illegal
);

  // Exactly one of ok / is_null / illegal is high for every code word.
  always_comb begin
    code_bit = 1'b0;
    ok       = 1'b0;
    is_null  = 1'b0;
    illegal  = 1'b0;
    unique case (code)
      CODE_ONE: begin
        code_bit = 1'b1;
        ok       = 1'b1;
      end
      CODE_ZERO:    ok      = 1'b1;
      CODE_NULL:    is_null = 1'b1;
      CODE_ILLEGAL: illegal = 1'b1;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dual_rail_capture.sv
// ---------------------------------------------------------------------------
// dual_rail_capture
// Captures a stream of dual-rail codes into a NUM_CYCLES-entry buffer and
// offers a registered read port that works in every state.
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   start      in   1    arms a capture (accepted in IDLE or DONE)
//   code_valid in   1    code_in is presented this cycle
//   code_in    in   2    dual-rail code {a, ~a}
//   rd_en      in   1    read request
//   rd_addr    in   AW   entry to read
//   rd_valid   out  1    rd_data is valid (rd_en delayed one cycle)
//   rd_data    out  2    entry read, {ok, bit}; 00 for out-of-range addresses
//   busy       out  1    capture in progress
//   done       out  1    buffer filled
//   count      out  CW   entries written since the last start
//   err        out  1    sticky illegal-code flag
//   err_count  out  4    illegal codes seen, saturating at 15
// ---------------------------------------------------------------------------
module dual_rail_capture
  import dual_rail_pkg::*;
#(
  parameter int NUM_CYCLES = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            code_valid,
  input  logic [1:0]                      code_in,
  input  logic                            rd_en,
  input  logic [$clog2(NUM_CYCLES)-1:0]   rd_addr,
  output logic                            rd_valid,
  output logic [1:0]                      rd_data,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(NUM_CYCLES+1)-1:0] count,
  output logic                            err,
  output logic [3:0]                      err_count
);

  localparam int AW = $clog2(NUM_CYCLES);
  localparam int CW = $clog2(NUM_CYCLES + 1);

  state_t         state;
  capture_entry_t mem [NUM_CYCLES];

  logic           dec_bit;
  logic           dec_ok;
  logic           dec_null;
  logic           dec_illegal;

  logic           start_accept;
  logic           capture_we;
  logic           last_entry;
  logic           rd_in_range;
  logic [AW-1:0]  wr_idx;
  capture_entry_t new_entry;

  dual_rail_decode u_decode (
    .code     (code_in),
    .code_bit (dec_bit),
    .ok       (dec_ok),
    .is_null  (dec_null),
    .illegal  (dec_illegal)
  );

  // Start is ignored while capturing. An accepted start takes the whole
  // cycle, so a code presented alongside it is dropped.
  // count never reaches NUM_CYCLES while in CAPTURE, so its low AW bits
  // address the buffer directly.
  always_comb begin
    start_accept = start && (state != ST_CAPTURE);
    capture_we   = (state == ST_CAPTURE) && code_valid && !dec_null && !start_accept;
    last_entry   = (count == CW'(NUM_CYCLES - 1));
    wr_idx       = count[AW-1:0];
    new_entry    = make_entry(dec_ok, dec_bit);
    rd_in_range  = (32'(rd_addr) < NUM_CYCLES);
  end

  // Reset wipes the buffer as well as the control state, so an aborted
  // capture leaves nothing behind. Reads sample the buffer before this
  // cycle's write lands, giving pre-write data on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      err       <= 1'b0;
      err_count <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < NUM_CYCLES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_addr] : 2'b00;
      end

      if (start_accept) begin
        state     <= ST_CAPTURE;
        count     <= '0;
        err       <= 1'b0;
        err_count <= '0;
      end else if (capture_we) begin
        mem[wr_idx] <= new_entry;
        count       <= count + 1'b1;
        if (last_entry) begin
          state <= ST_DONE;
        end
        if (dec_illegal) begin
          err <= 1'b1;
          if (err_count != 4'hF) begin
            err_count <= err_count + 4'd1;
          end
        end
      end
    end
  end

  // Decodes of the state register; the encoding keeps them mutually exclusive.
  assign busy = (state == ST_CAPTURE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_dual_rail_capture.sv
// ---------------------------------------------------------------------------
// tb_dual_rail_capture
// Randomized and directed stimulus for dual_rail_capture with a scoreboard.
// A second instance with a 20-entry buffer exercises err_count saturation.
// ---------------------------------------------------------------------------
module tb_dual_rail_capture;

  localparam int N  = 10;
  localparam int NB = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       code_valid;
  logic [1:0] code_in;
  logic       rd_en;
  logic [3:0] rd_addr;

  logic       rd_valid;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       err;
  logic [3:0] err_count;

  logic [4:0] big_addr;
  logic       big_rd_valid;
  logic [1:0] big_rd_data;
  logic       big_busy;
  logic       big_done;
  logic [4:0] big_count;
  logic       big_err;
  logic [3:0] big_err_count;

  assign big_addr = {1'b0, rd_addr};

  always #5 clk = ~clk;

  dual_rail_capture #(.NUM_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .code_valid (code_valid),
    .code_in    (code_in),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .err        (err),
    .err_count  (err_count)
  );

  dual_rail_capture #(.NUM_CYCLES(NB)) dut_big (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .code_valid (code_valid),
    .code_in    (code_in),
    .rd_en      (rd_en),
    .rd_addr    (big_addr),
    .rd_valid   (big_rd_valid),
    .rd_data    (big_rd_data),
    .busy       (big_busy),
    .done       (big_done),
    .count      (big_count),
    .err        (big_err),
    .err_count  (big_err_count)
  );

  typedef struct {
    int busy;
    int done;
    int count;
    int err;
    int ec;
    int rdv;
    bit chk_rd0;
  } status_t;

  status_t    st_q[$];
  logic [1:0] rd_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 capturing, 2 done.
  int         m_phase;
  int         m_count;
  int         m_ec;
  int         m_err;
  logic [1:0] m_buf [N];

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drives one cycle, advances the model, and after the edge hands the
  // expected outputs to the monitor.
  task automatic applyStimulus(input logic r, input logic s, input logic cv,
                               input logic [1:0] c, input logic re,
                               input logic [3:0] a);
    status_t    st;
    logic [1:0] rexp;
    bit         push_rd;
    rst        = r;
    start      = s;
    code_valid = cv;
    code_in    = c;
    rd_en      = re;
    rd_addr    = a;
    push_rd    = 1'b0;
    rexp       = 2'b00;
    st.chk_rd0 = 1'b0;
    if (r) begin
      m_phase = 0;
      m_count = 0;
      m_ec    = 0;
      m_err   = 0;
      for (int i = 0; i < N; i++) m_buf[i] = 2'b00;
      st.chk_rd0 = 1'b1;
    end else begin
      if (re) begin
        push_rd = 1'b1;
        rexp    = (int'(a) < N) ? m_buf[a] : 2'b00;
      end
      if (s && m_phase != 1) begin
        m_phase = 1;
        m_count = 0;
        m_ec    = 0;
        m_err   = 0;
      end else if (m_phase == 1 && cv && c != 2'b00) begin
        if (c == 2'b11) begin
          m_buf[m_count] = 2'b00;
          m_err = 1;
          if (m_ec < 15) m_ec++;
        end else begin
          m_buf[m_count] = {1'b1, (c == 2'b10)};
        end
        m_count++;
        if (m_count == N) m_phase = 2;
      end
    end
    st.busy  = (m_phase == 1) ? 1 : 0;
    st.done  = (m_phase == 2) ? 1 : 0;
    st.count = m_count;
    st.err   = m_err;
    st.ec    = m_ec;
    st.rdv   = (!r && re) ? 1 : 0;
    @(posedge clk);
    #1;
    st_q.push_back(st);
    if (push_rd) rd_q.push_back(rexp);
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    status_t st;
    logic [1:0] rexp;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0) begin
        st = st_q.pop_front();
        checkOutput("busy",      int'(busy),      st.busy);
        checkOutput("done",      int'(done),      st.done);
        checkOutput("count",     int'(count),     st.count);
        checkOutput("err",       int'(err),       st.err);
        checkOutput("err_count", int'(err_count), st.ec);
        checkOutput("rd_valid",  int'(rd_valid),  st.rdv);
        if (st.chk_rd0) checkOutput("rd_data_reset", int'(rd_data), 0);
      end
      if (rd_valid === 1'b1) begin
        if (rd_q.size() == 0) begin
          checkOutput("rd_unexpected", 1, 0);
        end else begin
          rexp = rd_q.pop_front();
          checkOutput("rd_data", int'(rd_data), int'(rexp));
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 2'b00, 0, 4'd0);
  endtask

  // Start followed by ten non-null codes 01,10,01,... with optional nulls
  // between them and an optional illegal code at one position.
  task automatic runCapture(input bit with_nulls, input int illegal_pos);
    logic [1:0] c;
    applyStimulus(0, 1, 0, 2'b00, 0, 4'd0);
    for (int i = 0; i < N; i++) begin
      if (with_nulls) applyStimulus(0, 0, 1, 2'b00, 0, 4'd0);
      if (i == illegal_pos) c = 2'b11;
      else c = ((i & 1) != 0) ? 2'b10 : 2'b01;
      applyStimulus(0, 0, 1, c, 0, 4'd0);
    end
    for (int a = 0; a <= N; a++) applyStimulus(0, 0, 0, 2'b00, 1, 4'(a));
    idle(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; code_valid = 1'b0; code_in = 2'b00;
    rd_en = 1'b0; rd_addr = 4'd0;

    applyStimulus(1, 0, 0, 2'b00, 0, 4'd0);
    applyStimulus(1, 0, 0, 2'b00, 0, 4'd0);
    for (int a = 0; a <= N; a++) applyStimulus(0, 0, 0, 2'b00, 1, 4'(a));

    $display("[TB] plain capture");
    runCapture(1'b0, -1);
    $display("[TB] capture with nulls");
    applyStimulus(1, 0, 0, 2'b00, 0, 4'd0);
    runCapture(1'b1, -1);
    $display("[TB] illegal code at position 3");
    runCapture(1'b0, 3);

    $display("[TB] start/valid collision");
    applyStimulus(1, 0, 0, 2'b00, 0, 4'd0);
    applyStimulus(0, 1, 1, 2'b10, 0, 4'd0);
    applyStimulus(0, 0, 1, 2'b01, 0, 4'd0);
    applyStimulus(0, 1, 1, 2'b10, 1, 4'd0);
    applyStimulus(0, 0, 0, 2'b00, 1, 4'd1);

    $display("[TB] err_count saturation");
    applyStimulus(1, 0, 0, 2'b00, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b00, 0, 4'd0);
    for (int i = 0; i < NB; i++) applyStimulus(0, 0, 1, 2'b11, 0, 4'd0);
    checkOutput("big_err_count", int'(big_err_count), 15);
    checkOutput("big_count",     int'(big_count),     NB);
    checkOutput("big_done",      int'(big_done),      1);
    checkOutput("big_err",       int'(big_err),       1);

    $display("[TB] reset mid-capture");
    applyStimulus(1, 0, 0, 2'b00, 0, 4'd0);
    applyStimulus(0, 1, 0, 2'b00, 0, 4'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 2'b10, 0, 4'd0);
    applyStimulus(1, 1, 1, 2'b01, 1, 4'd0);
    applyStimulus(0, 0, 0, 2'b00, 1, 4'd0);
    applyStimulus(0, 0, 0, 2'b00, 1, 4'd10);
    idle(1);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 59) == 0,
                    $urandom_range(0, 14) == 0,
                    $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)));
    end

    idle(3);
    checkOutput("rd_queue_drained", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
